// File: rtl/ahb_pkg.sv
// Shared AHB-Lite types and constants for the manager and its bus interface.
package ahb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } htrans_t;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic       HRESP_OKAY  = 1'b0;
    localparam logic       HRESP_ERROR = 1'b1;

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [2:0]        size;
        logic [DATA_W-1:0] wdata;
    } ahb_cmd_t;

    // Only byte transfers exist on an 8-bit data bus.
    function automatic logic size_legal(input logic [2:0] size);
        return size == HSIZE_BYTE;
    endfunction

endpackage

// File: rtl/ahb_manager_if.sv
// Command/response port plus AHB-Lite manager signals, bundled for ahb_manager.
interface ahb_manager_if;
    import ahb_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [2:0]        cmd_size;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic              rsp_write;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] haddr;
    htrans_t           htrans;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [DATA_W-1:0] hwdata;
    logic              hready;
    logic              hresp;
    logic [DATA_W-1:0] hrdata;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        input  hready, hresp, hrdata,
        output cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        output haddr, htrans, hwrite, hsize, hwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_size, cmd_wdata,
        output hready, hresp, hrdata,
        input  cmd_ready, rsp_valid, rsp_write, rsp_rdata, rsp_err,
        input  haddr, htrans, hwrite, hsize, hwdata
    );

endinterface

// File: rtl/ahb_manager.sv
// Single-transfer AHB-Lite manager: AP/DP pipeline with a HOLD slot that
// replays the address phase cancelled by a two-cycle ERROR response.
module ahb_manager
    import ahb_pkg::*;
(
    input  logic          hclk,
    input  logic          hreset_n,
    ahb_manager_if.master bus
);

    // state   | meaning
    // ST_RUN  | normal operation, AP/DP advance whenever hready is high
    // ST_ERR1 | first ERROR cycle seen; AP parked in HOLD, waiting for the second
    typedef enum logic {ST_RUN, ST_ERR1} state_t;

    state_t            state;
    ahb_cmd_t          ap;
    ahb_cmd_t          hold;
    ahb_cmd_t          cmd;
    logic              ap_valid;
    logic              hold_valid;
    logic              ap_on_bus;
    logic              accept;

    // DP only needs direction, legality and write data; the address has left the bus.
    logic              dp_valid;
    logic              dp_write;
    logic              dp_legal;
    logic [DATA_W-1:0] dp_wdata;

    assign cmd = '{write: bus.cmd_write, addr: bus.cmd_addr,
                   size: bus.cmd_size, wdata: bus.cmd_wdata};

    // Illegal sizes ride the pipeline for ordering but never reach the bus.
    assign ap_on_bus     = ap_valid && size_legal(ap.size);
    assign bus.htrans    = ap_on_bus ? NONSEQ : IDLE;
    assign bus.haddr     = ap_on_bus ? ap.addr : '0;
    assign bus.hwrite    = ap_on_bus && ap.write;
    assign bus.hsize     = ap_on_bus ? ap.size : HSIZE_BYTE;
    assign bus.hwdata    = (dp_valid && dp_write && dp_legal) ? dp_wdata : '0;
    assign bus.cmd_ready = hreset_n && bus.hready && !hold_valid && (state == ST_RUN);
    assign accept        = bus.cmd_valid && bus.cmd_ready;

    always_ff @(posedge hclk) begin
        if (!hreset_n) begin
            state         <= ST_RUN;
            ap            <= '0;
            hold          <= '0;
            ap_valid      <= 1'b0;
            hold_valid    <= 1'b0;
            dp_valid      <= 1'b0;
            dp_write      <= 1'b0;
            dp_legal      <= 1'b0;
            dp_wdata      <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
        end else begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_write <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.rsp_err   <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (dp_valid && dp_legal && !bus.hready && bus.hresp == HRESP_ERROR) begin
                        state <= ST_ERR1;
                        if (ap_valid) begin
                            hold       <= ap;
                            hold_valid <= 1'b1;
                            ap_valid   <= 1'b0;
                        end
                    end else if (bus.hready) begin
                        if (dp_valid) begin
                            bus.rsp_valid <= 1'b1;
                            bus.rsp_write <= dp_write;
                            bus.rsp_rdata <= (dp_write || !dp_legal) ? '0 : bus.hrdata;
                            bus.rsp_err   <= !dp_legal || (bus.hresp != HRESP_OKAY);
                        end
                        dp_valid <= ap_valid;
                        dp_write <= ap.write;
                        dp_legal <= size_legal(ap.size);
                        dp_wdata <= ap.wdata;
                        ap       <= cmd;
                        ap_valid <= accept;
                    end
                end
                ST_ERR1: begin
                    if (bus.hready) begin
                        bus.rsp_valid <= 1'b1;
                        bus.rsp_write <= dp_write;
                        bus.rsp_rdata <= dp_write ? '0 : bus.hrdata;
                        bus.rsp_err   <= 1'b1;
                        dp_valid      <= 1'b0;
                        ap            <= hold;
                        ap_valid      <= hold_valid;
                        hold_valid    <= 1'b0;
                        state         <= ST_RUN;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_manager.sv
// Bench for ahb_manager: a behavioural subordinate with random waits/errors and a
// command-level model of the responses, plus directed latency/error/reset scenarios.
module tb_ahb_manager;
    import ahb_pkg::*;

    localparam int LG = 8192;

    logic hclk;
    logic hreset_n;

    ahb_manager_if bus();

    ahb_manager dut (
        .hclk     (hclk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    typedef struct {
        logic       write;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] ref_mem[256];
    logic [7:0] sub_mem[256];
    int         n_chk = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         force_waits = 0;

    htrans_t     lg_trans[LG];
    logic [31:0] lg_addr[LG];
    logic        lg_write[LG];
    logic [7:0]  lg_wdata[LG];
    logic        lg_ready[LG];
    logic        lg_rspv[LG];
    logic        lg_rspw[LG];
    logic [7:0]  lg_rdata[LG];
    logic        lg_err[LG];

    initial begin
        hclk = 1'b0;
        forever #5 hclk = ~hclk;
    end

    always @(posedge hclk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Subordinate behaviour: address 0x20 and any address ending in 0xC return ERROR.
    function automatic logic is_err(input logic [31:0] a);
        return (a[7:0] == 8'h20) || (a[3:0] == 4'hC);
    endfunction

    function automatic int count_rsp(input int from, input int to);
        int n = 0;
        for (int i = from; i <= to; i++) if (lg_rspv[i % LG] === 1'b1) n++;
        return n;
    endfunction

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge hclk);
            #1;
        end
    endtask

    // Offer one command until accepted; acc is the first cycle after the accepting edge.
    task automatic issue(input logic w, input logic [31:0] a, input logic [2:0] sz,
                         input logic [7:0] d, output int acc);
        int   waited = 0;
        exp_t e;
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_size  = sz;
        bus.cmd_wdata = d;
        @(negedge hclk);
        while (bus.cmd_ready !== 1'b1 && waited < 50) begin
            @(negedge hclk);
            waited++;
        end
        if (bus.cmd_ready !== 1'b1) begin
            chk("issue_timeout", 32'(bus.cmd_ready), 32'd1);
            @(posedge hclk);
            #1;
            bus.cmd_valid = 1'b0;
            acc = -1;
            return;
        end
        e.write = w;
        if (sz != 3'd0) begin
            e.rdata = 8'h00;
            e.err   = 1'b1;
        end else begin
            e.err = is_err(a);
            if (w) begin
                e.rdata = 8'h00;
                if (!e.err) ref_mem[a[7:0]] = d;
            end else begin
                e.rdata = e.err ? 8'h00 : ref_mem[a[7:0]];
            end
        end
        exp_q.push_back(e);
        @(posedge hclk);
        #1;
        acc = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic drain();
        int w = 0;
        while (exp_q.size() != 0 && w < 200) begin
            tick(1);
            w++;
        end
        chk("drain_pending", 32'(exp_q.size()), 32'd0);
        tick(3);
    endtask

    // Behavioural AHB-Lite subordinate.
    initial begin : subordinate
        logic        d_act, d_write, d_err;
        logic [7:0]  d_addr;
        int          d_waits, d_stage;
        logic        s_rst, s_rdy, s_wr;
        htrans_t     s_trans;
        logic [31:0] s_addr;
        logic [7:0]  s_wd;
        d_act = 1'b0; d_write = 1'b0; d_err = 1'b0; d_addr = 8'h00;
        d_waits = 0; d_stage = 0;
        bus.hready = 1'b1;
        bus.hresp  = 1'b0;
        bus.hrdata = 8'h00;
        forever begin
            @(negedge hclk);
            s_rst   = hreset_n;
            s_rdy   = bus.hready;
            s_trans = bus.htrans;
            s_addr  = bus.haddr;
            s_wr    = bus.hwrite;
            s_wd    = bus.hwdata;
            @(posedge hclk);
            #1;
            if (s_rst !== 1'b1) begin
                d_act = 1'b0;
            end else begin
                if (d_act && s_rdy) begin
                    if (d_write && !d_err) sub_mem[d_addr] = s_wd;
                    d_act = 1'b0;
                end else if (d_act) begin
                    d_stage++;
                end
                if (s_rdy && s_trans == NONSEQ) begin
                    d_act   = 1'b1;
                    d_addr  = s_addr[7:0];
                    d_write = s_wr;
                    d_err   = is_err(s_addr);
                    d_stage = 0;
                    if (force_waits >= 0) d_waits = force_waits;
                    else d_waits = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
                end
            end
            if (!d_act) begin
                bus.hready = 1'b1; bus.hresp = 1'b0; bus.hrdata = 8'h00;
            end else if (d_stage < d_waits) begin
                bus.hready = 1'b0; bus.hresp = 1'b0; bus.hrdata = 8'h00;
            end else if (d_err) begin
                bus.hready = (d_stage != d_waits); bus.hresp = 1'b1; bus.hrdata = 8'h00;
            end else begin
                bus.hready = 1'b1; bus.hresp = 1'b0;
                bus.hrdata = d_write ? 8'h00 : sub_mem[d_addr];
            end
        end
    end

    // Bus log plus in-order response scoreboard.
    initial begin : monitor
        exp_t e;
        int   k;
        forever begin
            @(negedge hclk);
            k = cyc % LG;
            lg_trans[k] = bus.htrans;
            lg_addr[k]  = bus.haddr;
            lg_write[k] = bus.hwrite;
            lg_wdata[k] = bus.hwdata;
            lg_ready[k] = bus.cmd_ready;
            lg_rspv[k]  = bus.rsp_valid;
            lg_rspw[k]  = bus.rsp_write;
            lg_rdata[k] = bus.rsp_rdata;
            lg_err[k]   = bus.rsp_err;
            if (bus.rsp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("rsp_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_write", 32'(bus.rsp_write), 32'(e.write));
                    chk("rsp_rdata", 32'(bus.rsp_rdata), 32'(e.rdata));
                    chk("rsp_err", 32'(bus.rsp_err), 32'(e.err));
                end
            end
            if (bus.htrans == NONSEQ) begin
                chk("nonseq_hsize", 32'(bus.hsize), 32'd0);
                chk("nonseq_illegal_addr", 32'(bus.haddr[31]), 32'd0);
            end
        end
    end

    initial begin : main
        int         a, b, dummy;
        logic       w, ill;
        logic [7:0] d;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i] = 8'(i * 37 + 11);
            sub_mem[i] = 8'(i * 37 + 11);
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_size  = 3'd0;
        bus.cmd_wdata = 8'h00;
        hreset_n = 1'b0;

        // Reset held for two edges
        tick(2);
        @(negedge hclk);
        chk("rst_htrans", 32'(bus.htrans), 32'(IDLE));
        chk("rst_haddr", bus.haddr, 32'd0);
        chk("rst_hwrite", 32'(bus.hwrite), 32'd0);
        chk("rst_hsize", 32'(bus.hsize), 32'd0);
        chk("rst_hwdata", 32'(bus.hwdata), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_write", 32'(bus.rsp_write), 32'd0);
        chk("rst_rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        chk("rst_rsp_err", 32'(bus.rsp_err), 32'd0);
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        tick(1);

        // Zero-wait write then read, back to back
        force_waits = 0;
        issue(1'b1, 32'h10, 3'd0, 8'hA5, a);
        issue(1'b0, 32'h10, 3'd0, 8'h00, b);
        tick(5);
        chk("b2b_accept", 32'(b), 32'(a + 1));
        chk("wr_ap_htrans", 32'(lg_trans[a % LG]), 32'(NONSEQ));
        chk("wr_ap_haddr", lg_addr[a % LG], 32'h10);
        chk("wr_ap_hwrite", 32'(lg_write[a % LG]), 32'd1);
        chk("rd_ap_htrans", 32'(lg_trans[(a + 1) % LG]), 32'(NONSEQ));
        chk("rd_ap_hwrite", 32'(lg_write[(a + 1) % LG]), 32'd0);
        chk("wr_dp_hwdata", 32'(lg_wdata[(a + 1) % LG]), 32'hA5);
        chk("wr_rsp_not_early", 32'(lg_rspv[(a + 1) % LG]), 32'd0);
        chk("wr_rsp_valid", 32'(lg_rspv[(a + 2) % LG]), 32'd1);
        chk("wr_rsp_write", 32'(lg_rspw[(a + 2) % LG]), 32'd1);
        chk("wr_rsp_err", 32'(lg_err[(a + 2) % LG]), 32'd0);
        chk("rd_rsp_valid", 32'(lg_rspv[(a + 3) % LG]), 32'd1);
        chk("rd_rsp_rdata", 32'(lg_rdata[(a + 3) % LG]), 32'hA5);
        drain();

        // Two wait states on a read, with a write queued behind it
        force_waits = 2;
        issue(1'b0, 32'h10, 3'd0, 8'h00, a);
        issue(1'b1, 32'h11, 3'd0, 8'h3C, b);
        tick(10);
        chk("ws_accept", 32'(b), 32'(a + 1));
        chk("ws_ready_0", 32'(lg_ready[(a + 1) % LG]), 32'd0);
        chk("ws_ready_1", 32'(lg_ready[(a + 2) % LG]), 32'd0);
        chk("ws_haddr_0", lg_addr[(a + 1) % LG], 32'h11);
        chk("ws_haddr_1", lg_addr[(a + 2) % LG], 32'h11);
        chk("ws_haddr_2", lg_addr[(a + 3) % LG], 32'h11);
        chk("ws_htrans_2", 32'(lg_trans[(a + 3) % LG]), 32'(NONSEQ));
        chk("ws_rsp_late", 32'(lg_rspv[(a + 2) % LG]), 32'd0);
        chk("ws_rsp_valid", 32'(lg_rspv[(a + 4) % LG]), 32'd1);
        chk("ws_rsp_rdata", 32'(lg_rdata[(a + 4) % LG]), 32'hA5);
        chk("ws_hwdata_0", 32'(lg_wdata[(a + 4) % LG]), 32'h3C);
        chk("ws_hwdata_2", 32'(lg_wdata[(a + 6) % LG]), 32'h3C);
        force_waits = 0;
        drain();

        // ERROR on a write while a read sits in the address phase
        issue(1'b1, 32'h20, 3'd0, 8'h77, a);
        issue(1'b0, 32'h24, 3'd0, 8'h00, b);
        tick(10);
        chk("err_ap_read", lg_addr[(a + 1) % LG], 32'h24);
        chk("err_cycle2_idle", 32'(lg_trans[(a + 2) % LG]), 32'(IDLE));
        chk("err_rsp_valid", 32'(lg_rspv[(a + 3) % LG]), 32'd1);
        chk("err_rsp_err", 32'(lg_err[(a + 3) % LG]), 32'd1);
        chk("err_rsp_write", 32'(lg_rspw[(a + 3) % LG]), 32'd1);
        chk("replay_htrans", 32'(lg_trans[(a + 3) % LG]), 32'(NONSEQ));
        chk("replay_haddr", lg_addr[(a + 3) % LG], 32'h24);
        chk("replay_rsp_valid", 32'(lg_rspv[(a + 5) % LG]), 32'd1);
        chk("replay_rsp_err", 32'(lg_err[(a + 5) % LG]), 32'd0);
        chk("err_rsp_count", 32'(count_rsp(a, a + 10)), 32'd2);
        drain();

        // Illegal size behind a legal write
        issue(1'b1, 32'h30, 3'd0, 8'h5E, a);
        issue(1'b0, 32'h8000_0031, 3'd1, 8'h00, b);
        tick(6);
        chk("ill_no_nonseq_0", 32'(lg_trans[(a + 1) % LG]), 32'(IDLE));
        chk("ill_no_nonseq_1", 32'(lg_trans[(a + 2) % LG]), 32'(IDLE));
        chk("ill_prev_rsp_err", 32'(lg_err[(a + 2) % LG]), 32'd0);
        chk("ill_rsp_valid", 32'(lg_rspv[(a + 3) % LG]), 32'd1);
        chk("ill_rsp_err", 32'(lg_err[(a + 3) % LG]), 32'd1);
        chk("ill_rsp_rdata", 32'(lg_rdata[(a + 3) % LG]), 32'd0);
        drain();

        // Randomized traffic with random waits and address-driven errors
        force_waits = -1;
        for (int n = 0; n < 300; n++) begin
            tick($urandom_range(0, 2));
            w   = 1'($urandom_range(0, 1));
            ill = ($urandom_range(0, 9) == 0);
            d   = 8'($urandom_range(0, 255));
            if (ill)
                issue(w, 32'h8000_0000 | 32'($urandom_range(0, 255)), 3'($urandom_range(1, 7)), d, dummy);
            else
                issue(w, 32'($urandom_range(0, 255)), 3'd0, d, dummy);
        end
        drain();

        // Reset during a stalled data phase abandons the transfer
        force_waits = 4;
        issue(1'b0, 32'h40, 3'd0, 8'h00, a);
        tick(1);
        hreset_n = 1'b0;
        exp_q.delete();
        tick(1);
        @(negedge hclk);
        chk("mid_rst_htrans", 32'(bus.htrans), 32'(IDLE));
        chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("mid_rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge hclk);
        #1;
        hreset_n = 1'b1;
        force_waits = 0;
        tick(6);
        chk("mid_rst_no_rsp", 32'(count_rsp(a + 2, a + 8)), 32'd0);
        chk("mid_rst_bus_idle", 32'(lg_trans[(a + 3) % LG]), 32'(IDLE));

        // Recovery after reset
        issue(1'b1, 32'h41, 3'd0, 8'hC3, dummy);
        issue(1'b0, 32'h41, 3'd0, 8'h00, dummy);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
